// File: rtl/uart_rx_fifo_if.sv
// Purpose : bus bundle between the UART receiver, the RX byte FIFO and the CPU read side.
// Ports   : receiver side in_data/in_valid/in_ready; CPU side rd_en/rd_data/rd_valid,
//           clr_flags; status count/empty/full/overrun/timeout/irq.
// The slave modport is the FIFO's view; the master modport is the view of whoever drives it.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                rd_en;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                overrun;
  logic                timeout;
  logic                clr_flags;
  logic                irq;

  modport slave (
    input  in_data, in_valid, rd_en, clr_flags,
    output in_ready, rd_data, rd_valid, count, empty, full, overrun, timeout, irq
  );

  modport master (
    output in_data, in_valid, rd_en, clr_flags,
    input  in_ready, rd_data, rd_valid, count, empty, full, overrun, timeout, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose : circular byte FIFO behind the UART receiver, with threshold/overrun/idle-timeout irq.
// Latency : 1 clock from rd_en to rd_data/rd_valid; status outputs come straight from registers.
// Backpressure: none toward the receiver (in_ready tied high); bytes arriving while full are
//           dropped and flagged as overrun.
// Ports   : clk, rst (synchronous, active-high), bus (uart_rx_fifo_if.slave).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int THRESHOLD      = 8,
  parameter int TIMEOUT_CYCLES = 4340
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  // Idle counter must be able to hold TIMEOUT_CYCLES itself (its parking value).
  localparam int IW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] THR_CNT   = CW'(THRESHOLD);
  localparam logic [IW-1:0] IDLE_FIRE = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(TIMEOUT_CYCLES);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [7:0]            rd_data_q;
  logic                  rd_valid_q;
  logic                  overrun_q;
  logic                  timeout_q;
  logic [IW-1:0]         idle_q;

  logic empty_w;
  logic full_w;
  logic pop;
  logic push;
  logic drop;
  logic timeout_set;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_CNT);

  // No fall-through: an empty FIFO never pops, even with a push in the same cycle.
  assign pop  = bus.rd_en && !empty_w;
  // At full, a same-cycle pop frees the slot the incoming byte lands in.
  assign push = bus.in_valid && (!full_w || pop);
  assign drop = bus.in_valid && full_w && !pop;

  // Fires exactly once per idle stretch: the counter moves past IDLE_FIRE and parks
  // at IDLE_SAT, so a clr_flags while still idle is not immediately undone.
  assign timeout_set = !empty_w && (idle_q == IDLE_FIRE);

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      idle_q     <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (push || empty_w) begin
        idle_q <= '0;
      end else if (idle_q != IDLE_SAT) begin
        idle_q <= idle_q + 1'b1;
      end

      // Set takes priority over clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_flags) begin
        overrun_q <= 1'b0;
      end

      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (bus.clr_flags) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready = 1'b1;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.overrun  = overrun_q;
  assign bus.timeout  = timeout_q;
  assign bus.irq      = (count_q >= THR_CNT) | overrun_q | timeout_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed, scoreboard-checked bench for uart_rx_fifo.
// Each cycle drives inputs 1 time unit after the rising edge and samples outputs 1 time
// unit after the next rising edge; popped bytes are compared against a queue of expected bytes.
module tb_uart_rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int THRESHOLD  = 8;
  localparam int TMO        = 4340;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .THRESHOLD     (THRESHOLD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total  = 0;
  int         passed = 0;
  logic [7:0] exp_q[$];
  logic       m_ovr  = 1'b0;
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.rd_en     = 1'b0;
    bus.clr_flags = 1'b0;
  endtask

  // One clock of stimulus; the reference model predicts pop/push/drop from its own queue.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic       p;
    logic       w;
    logic [7:0] e;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.rd_en     = r;
    bus.clr_flags = c;
    p = r && (exp_q.size() != 0);
    w = v && ((exp_q.size() != DEPTH) || p);
    if (v && !w)  m_ovr = 1'b1;
    else if (c)   m_ovr = 1'b0;
    e = last_rd;
    if (p) e = exp_q.pop_front();
    if (w) exp_q.push_back(d);
    @(posedge clk);
    #1;
    idle_inputs();
    last_rd = e;
    chk("rd_valid", 32'(bus.rd_valid), 32'(p));
    chk("rd_data",  32'(bus.rd_data),  32'(e));
    chk("count",    32'(bus.count),    32'(exp_q.size()));
    chk("empty",    32'(bus.empty),    32'(exp_q.size() == 0));
    chk("full",     32'(bus.full),     32'(exp_q.size() == DEPTH));
    chk("overrun",  32'(bus.overrun),  32'(m_ovr));
    chk("in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  // Reset asserted while traffic and clr_flags are all active.
  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hEE;
    bus.rd_en     = 1'b1;
    bus.clr_flags = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    exp_q.delete();
    m_ovr   = 1'b0;
    last_rd = 8'h00;
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_irq",      32'(bus.irq),      32'd0);
    chk("rst_rd_data",  32'(bus.rd_data),  32'h00);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_overrun",  32'(bus.overrun),  32'd0);
    chk("rst_timeout",  32'(bus.timeout),  32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    do_reset();

    // Ordering, 1-clock read latency
    cyc(1'b1, 8'h41, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0);
    cyc(1'b1, 8'h43, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("order_last", 32'(last_rd), 32'h43);
    // Pop while empty is ignored, and push+pop on empty pops nothing
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("nofall_last", 32'(last_rd), 32'h77);

    // Full and overrun: 17 pushes, 0x10 is dropped
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("ovr_full",  32'(bus.full),    32'd1);
    chk("ovr_count", 32'(bus.count),   32'd16);
    chk("ovr_flag",  32'(bus.overrun), 32'd1);
    chk("ovr_irq",   32'(bus.irq),     32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovr_last",  32'(last_rd),     32'h0F);
    chk("ovr_irq_held", 32'(bus.irq),  32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_clr_irq", 32'(bus.irq),   32'd0);

    // Simultaneous push/pop at full, pointer wrap
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("wrap_count",   32'(bus.count),   32'd16);
    chk("wrap_overrun", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", 32'(last_rd), 32'hAA);

    // Threshold
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("thr_irq7", 32'(bus.irq), 32'd0);
    cyc(1'b1, 8'h67, 1'b0, 1'b0);
    chk("thr_irq8", 32'(bus.irq), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("thr_irq_pop", 32'(bus.irq), 32'd0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Timeout exactly TMO clocks after the push
    cyc(1'b1, 8'h91, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_before", 32'(bus.timeout), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_set", 32'(bus.timeout), 32'd1);
    chk("tmo_irq", 32'(bus.irq),     32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("tmo_clr", 32'(bus.timeout), 32'd0);

    // A push at TMO-2 restarts the idle count
    cyc(1'b1, 8'h92, 1'b0, 1'b0);
    for (int i = 0; i < TMO - 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h93, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_restart_orig", 32'(bus.timeout), 32'd0);
    for (int i = 0; i < TMO - 2; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_restart_before", 32'(bus.timeout), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_restart_set", 32'(bus.timeout), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tmo_drain_last", 32'(last_rd), 32'h93);

    // Empty FIFO never times out
    for (int i = 0; i < TMO + 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tmo_empty", 32'(bus.timeout), 32'd0);
    chk("tmo_empty_irq", 32'(bus.irq), 32'd0);

    // Reset mid-transfer discards stored bytes
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_byte", 32'(last_rd), 32'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It consumes the receiver's byte and valid/ready handshake and stores bytes in a circular FIFO. The CPU peripheral bus pops bytes through a registered read port. The block also raises a level interrupt on a fill threshold, a sticky overrun, or an idle timeout.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16).
THRESHOLD, 8, fill level at or above which irq_level asserts (1..depth).
TIMEOUT_CYCLES, 4340, idle clocks with FIFO non-empty and no push before timeout flag sets (≈10 bit times at 50 MHz/115200).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_data  input  8  byte from UART receiver
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted this cycle
rd_en  input  1  CPU pop request
rd_data  output  8  popped byte, registered
rd_valid  output  1  one-cycle pulse, rd_data updated
count  output  DEPTH_LOG2+1  current occupancy 0..depth
empty  output  1  count == 0
full  output  1  count == depth
overrun  output  1  sticky: byte dropped because FIFO full
timeout  output  1  sticky: idle timeout expired
clr_flags  input  1  clears overrun and timeout
irq  output  1  irq_level | overrun | timeout

Behaviour:
- Reset: one clock, synchronous, active-high; rst dominates all other inputs. Reset values: pointers=0, count=0, rd_data=0x00, rd_valid=0, overrun=0, timeout=0, idle counter=0. Resulting outputs: empty=1, full=0, irq=0, in_ready=1. Reset mid-transfer discards all stored bytes.
- in_ready is tied to 1 and never deasserts, so the receiver is never stalled. A serial line cannot be back-pressured.
- Push: in_valid=1 with the FIFO not full writes in_data at wr_ptr. wr_ptr increments modulo depth and count increments.
- Push while full with no pop in the same cycle: the byte is dropped, overrun sets, and FIFO contents are unchanged.
- Pop: rd_en=1 with the FIFO not empty loads rd_data from rd_ptr on the next edge. rd_valid pulses high for that one cycle, rd_ptr increments modulo depth, and count decrements. Latency is 1 clock from rd_en to rd_data/rd_valid.
- rd_en while empty is ignored: rd_valid=0 and rd_data holds. There is no fall-through, so a push and pop in the same cycle on an empty FIFO pops nothing.
- Push and pop in the same cycle, not empty: both occur and count is unchanged.
- Push and pop in the same cycle at full: both occur, the byte is accepted, count stays at depth, and overrun does not set.
- Pointers are DEPTH_LOG2 bits and wrap naturally. count is tracked explicitly, and full/empty are derived from count.
- irq_level = (count >= THRESHOLD), combinational from registered count.
- Idle counter:
  - Resets to 0 on any accepted push, or whenever the FIFO is empty.
  - Otherwise increments each clock, saturating.
  - When it reaches TIMEOUT_CYCLES-1, timeout sets on the next edge.
  - timeout is sticky; the counter holds until the next push or until the FIFO empties.
- clr_flags clears overrun and timeout. If a set condition occurs in the same cycle as clr_flags, the set wins.
- irq and all status outputs are functions of registers only. There are no combinational paths from in_valid or rd_en to outputs except the constant in_ready.

Test Plan:
- Reset: assert rst with traffic active → next cycle count=0, empty=1, irq=0, rd_data=0x00, rd_valid=0.
- Ordering: push 0x41, 0x42, 0x43, then pop three times → rd_valid pulses with rd_data 0x41, 0x42, 0x43, each 1 clock after its rd_en; empty=1 after the third pop.
- Full/overrun: push 17 bytes 0x00..0x10 → full=1, count=16, overrun=1. Pop 16 → 0x00..0x0F; 0x10 is lost. clr_flags → overrun=0.
- Wrap-around and simultaneous push/pop: fill to 16, then push 0xAA and pop in the same cycle → count stays 16, overrun=0. Drain → last byte 0xAA. Pointers have wrapped correctly.
- Threshold: push 7 bytes → irq=0; push the 8th → irq=1 on the next cycle; one pop → irq=0.
- Timeout: push 1 byte then idle → timeout=1 exactly TIMEOUT_CYCLES clocks after the push; a push at TIMEOUT_CYCLES-2 restarts the count. Empty FIFO never times out.
